// File: rtl/ifetch_unit.sv
// Instruction fetch: samples IP, issues one read at a time, queues {pc, inst} for decode.
// Latency: 3 edges from IP sample to inst_valid (issue, accept, response push).
// Backpressure: stops issuing while the queue is full; mem request held until ready.
// Optional: define IFETCH_ILLEGAL_CHECK_EN to build the head-instruction legality check.
module ifetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              IP,
  input  logic                     flush,
  output logic                     mem_req_valid,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [6:0]               OP,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     inst_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   last_addr;
  logic [31:0]   req_addr;
  logic          need_fetch;
  logic          drop_pend;
  logic          issue;
  logic          push;
  logic          pop;
  entry_t        q [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;

  // Next-state and per-cycle strobes; a flush turns any in-flight fetch into a drop.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt != FULL && (need_fetch || IP != last_addr)) begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = (drop_pend || flush) ? DROP : WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          push    = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request address, last sampled IP, refetch and pending-drop flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_addr   <= '0;
      last_addr  <= '0;
      need_fetch <= 1'b1;
      drop_pend  <= 1'b0;
    end else begin
      if (issue) begin
        req_addr   <= IP;
        last_addr  <= IP;
        need_fetch <= 1'b0;
      end
      // A flush forces the next fetch even if IP matches the last address.
      if (flush) need_fetch <= 1'b1;
      if (state_q == REQ) begin
        if (mem_req_ready) drop_pend <= 1'b0;
        else if (flush)    drop_pend <= 1'b1;
      end else begin
        drop_pend <= 1'b0;
      end
    end
  end

  assign pop = inst_valid && inst_ready;

  // Instruction queue: flush empties it and takes priority over push/pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= '{pc: req_addr, inst: mem_rsp_data};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head          = q[rd_ptr];
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = req_addr;
  assign inst_valid    = (cnt != '0);
  assign inst          = head.inst;
  assign inst_pc       = head.pc;
  assign OP            = inst_valid ? head.inst[6:0] : 7'b0000000;
  assign count         = cnt;

`ifdef IFETCH_ILLEGAL_CHECK_EN
  assign inst_illegal = inst_valid && (head.inst[1:0] != 2'b11 || head.inst == 32'h00000000);
`else
  assign inst_illegal = 1'b0;
`endif

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit between the program counter and instruction memory. Samples the PC's instruction pointer, issues one read request at a time over a valid/ready request channel, and buffers returned words with their addresses in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake. The opcode of the queue head is returned to the PC for its stall/jump decision, and a flush input discards queued and in-flight fetches on a redirect.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high.
- IP  in  32  instruction pointer from the PC.
- flush  in  1  redirect; drop all queued and in-flight fetches.
- mem_req_valid  out  1  read request valid.
- mem_req_addr  out  32  read address; stable while valid && !ready.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  one-cycle pulse; read data valid.
- mem_rsp_data  in  32  instruction word.
- inst_valid  out  1  queue non-empty.
- inst  out  32  head instruction.
- inst_pc  out  32  address of head instruction.
- inst_ready  in  1  decode pops head when inst_valid && inst_ready.
- OP  out  7  inst[6:0] when inst_valid, else 7'b0000000.
- count  out  $clog2(DEPTH)+1  queue occupancy.
- inst_illegal  out  1  see Configuration.

## Operation
- Internal state: fetch FSM {IDLE, REQ, WAIT, DROP}, last_addr (32), need_fetch (1), queue of {pc, inst}, and rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- IDLE: if count < DEPTH (pop this cycle not counted) and (need_fetch || IP != last_addr), then latch mem_req_addr <= IP and last_addr <= IP, clear need_fetch, and go to REQ.
- REQ: mem_req_valid=1. On mem_req_ready, go to WAIT, or to DROP if a flush occurred while in REQ. The request is never withdrawn.
- WAIT: on mem_rsp_valid, push {mem_req_addr, mem_rsp_data} and go to IDLE.
- DROP: on mem_rsp_valid, discard the data and go to IDLE.
- flush, any state: the queue is emptied at the edge and need_fetch is set. WAIT goes to DROP. REQ stays in REQ with a pending-drop flag, so the accepted request goes to DROP. IDLE is unaffected except for need_fetch. A response arriving in WAIT in the same cycle as flush is discarded, and the state goes to IDLE.
- Push and pop in the same cycle: count is unchanged. Pop when empty: ignored. A push can never see a full queue, because the IDLE check guarantees a free slot.
- flush together with pop: flush wins and count goes to 0.
- mem_rsp_valid in IDLE or REQ is a protocol error and is ignored.

## Timing
- Reset values: state IDLE, need_fetch=1, last_addr=0, count=0, mem_req_valid=0, mem_req_addr=0, inst_valid=0, inst=0, inst_pc=0, OP=0, inst_illegal=0.
- inst, inst_pc, OP, inst_valid, and inst_illegal are driven from the registered queue head. They have no combinational path from mem_rsp_*.
- OP is combinational from the head register only.
- Minimum latency from IP sample to inst_valid is 3 edges:
  - edge 0: IDLE→REQ.
  - edge 1: accept, REQ→WAIT.
  - edge 2: response pushed; inst_valid high after edge 2.
- Throughput: at most one fetch per 3 cycles (single outstanding request).
- Reset mid-operation: all state returns to reset values at the edge. A later stale mem_rsp_valid is ignored because the FSM is in IDLE.

## Configuration
- IFETCH_ILLEGAL_CHECK_EN defined: inst_illegal = inst_valid && (inst[1:0] != 2'b11 || inst == 32'h00000000). The output is combinational from the head.
- IFETCH_ILLEGAL_CHECK_EN undefined: inst_illegal is tied to 0 and no check logic is built.

## Test plan
- Reset, then IP=0x0 held, ready=1, response 1 cycle after accept with data 0x00000013 → mem_req_addr=0x0, inst_valid after edge 2, inst_pc=0x0, OP=7'h13.
- IP stepping 0x0,0x4,…, inst_ready=0, DEPTH=4 → exactly 4 words queued, count=4, no further mem_req_valid until one pop, then fetch resumes with the current IP.
- flush in WAIT, response the next cycle with 0xDEADBEEF → queue empty, word discarded, next request re-issues the current IP even if it equals last_addr.
- flush while REQ is stalled (mem_req_ready=0 for 3 cycles) → mem_req_addr stable, request accepted, state goes to DROP, response dropped, count=0.
- Queue holding 2 entries, simultaneous push and pop → count stays 2, order preserved, pointers wrap correctly after 2·DEPTH transactions.
- With IFETCH_ILLEGAL_CHECK_EN, response 0x00000000 → inst_illegal=1. Response 0x0000006F → inst_illegal=0 and OP=7'h6F. Without the macro → inst_illegal=0 for both.
